// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 packet engine.
// Holds the FSM state, response status codes, RW codes and default framing bytes.
package rs232_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_RW,
        S_DATA,
        S_CHK,
        S_TAIL,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_CHK  = 8'h01;
    localparam logic [7:0] ST_TAIL = 8'h02;
    localparam logic [7:0] ST_RW   = 8'h03;

    localparam logic [7:0] RW_RD = 8'h00;
    localparam logic [7:0] RW_WR = 8'h01;

    localparam logic [7:0] DEF_HEAD = 8'hA5;
    localparam logic [7:0] DEF_TAIL = 8'h5A;

endpackage

// File: rtl/rs232_pkt_tx.sv
// Response serializer: HEAD, STATUS, DATA (MSB first), RCHK, TAIL.
// Latency: tx_req rises the cycle after start; each byte follows its ack by one cycle.
// Backpressure: tx_data/tx_req hold until tx_ack; done pulses with the TAIL ack.
module rs232_pkt_tx
    import rs232_pkg::*;
#(
    parameter int         DATA_BYTES = 2,
    parameter logic [7:0] HEAD       = DEF_HEAD,
    parameter logic [7:0] TAIL       = DEF_TAIL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              status,
    input  logic [8*DATA_BYTES-1:0] data,
    output logic [7:0]              tx_data,
    output logic                    tx_req,
    input  logic                    tx_ack,
    output logic                    done
);

    localparam int NB = DATA_BYTES + 4;
    localparam int BW = 8 * NB;

    logic [BW-1:0] buf_q;
    logic [7:0]    idx_q;
    logic          active_q;
    logic [7:0]    rchk;

    always_comb begin
        rchk = status;
        for (int i = 0; i < DATA_BYTES; i++) begin
            rchk = rchk + data[8*i +: 8];
        end
    end

    // The outgoing byte is always the top of the buffer; zeros shift in behind it.
    assign tx_data = buf_q[BW-1 -: 8];
    assign tx_req  = active_q;
    assign done    = active_q && tx_ack && (idx_q == 8'(NB - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            buf_q    <= {HEAD, status, data, rchk, TAIL};
            idx_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q && tx_ack) begin
            buf_q <= buf_q << 8;
            idx_q <= idx_q + 8'd1;
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs232_pkt_engine.sv
// Command packet parser/executor for the RS232 link with a status-bearing response.
// Latency: register strobe at T+1, capture at T+2, response HEAD at T+3 after the TAIL byte.
// Backpressure: response bytes wait on tx_ack; rx bytes arriving while executing/responding are dropped and counted.
module rs232_pkt_engine
    import rs232_pkg::*;
#(
    parameter int         ADDR_BYTES  = 1,
    parameter int         DATA_BYTES  = 2,
    parameter logic [7:0] HEAD        = DEF_HEAD,
    parameter logic [7:0] TAIL        = DEF_TAIL,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         ERR_CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_req,
    input  logic                    tx_ack,
    output logic [8*ADDR_BYTES-1:0] reg_addr,
    output logic [8*DATA_BYTES-1:0] reg_wdata,
    output logic                    reg_we,
    output logic                    reg_re,
    input  logic [8*DATA_BYTES-1:0] reg_rdata,
    output logic                    pkt_ok,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic                    busy
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int DW    = 8 * DATA_BYTES;
    localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q;
    logic [AW-1:0]      addr_sh;
    logic [DW-1:0]      data_sh;
    logic [7:0]         rw_q, chk_acc, chk_rx, status_q;
    logic [GAP_W-1:0]   gap_q;
    logic               in_pkt, timeout, drop, tx_start, tx_done;
    logic [DW-1:0]      resp_data;
    logic [1:0]         err_inc;
    logic [ERR_CNT_W:0] err_sum;

    assign in_pkt  = state_q inside {S_ADDR, S_RW, S_DATA, S_CHK, S_TAIL};
    // A byte on the expiry cycle wins over the timeout.
    assign timeout = in_pkt && !rx_valid && (gap_q == GAP_W'(TIMEOUT_CYC - 1));
    assign drop    = rx_valid && (state_q inside {S_EXEC, S_CAPT, S_RESP});

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        reg_we   = 1'b0;
        reg_re   = 1'b0;
        pkt_ok   = 1'b0;
        tx_start = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (rx_valid && rx_byte == HEAD) state_d = S_ADDR;
            S_ADDR: if (rx_valid && cnt_q == 8'(ADDR_BYTES - 1)) state_d = S_RW;
            S_RW:   if (rx_valid) state_d = S_DATA;
            S_DATA: if (rx_valid && cnt_q == 8'(DATA_BYTES - 1)) state_d = S_CHK;
            S_CHK:  if (rx_valid) state_d = S_TAIL;
            S_TAIL: if (rx_valid) state_d = S_EXEC;
            S_EXEC: begin
                reg_we  = (status_q == ST_OK) && (rw_q == RW_WR);
                reg_re  = (status_q == ST_OK) && (rw_q == RW_RD);
                state_d = S_CAPT;
            end
            S_CAPT: begin
                pkt_ok   = (status_q == ST_OK);
                tx_start = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: if (tx_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_comb begin
        err_inc = {1'b0, (state_q == S_CAPT && status_q != ST_OK) || timeout} + {1'b0, drop};
        err_sum = {1'b0, err_cnt} + (ERR_CNT_W + 1)'(err_inc);
        if (status_q != ST_OK)   resp_data = '0;
        else if (rw_q == RW_RD)  resp_data = reg_rdata;
        else                     resp_data = data_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rw_q      <= '0;
            chk_acc   <= '0;
            chk_rx    <= '0;
            status_q  <= ST_OK;
            gap_q     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            if (rx_valid || !in_pkt) gap_q <= '0;
            else                     gap_q <= gap_q + 1'b1;

            if (rx_valid) begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q   <= '0;
                        chk_acc <= '0;
                    end
                    S_ADDR: begin
                        addr_sh <= (addr_sh << 8) | AW'(rx_byte);
                        chk_acc <= chk_acc + rx_byte;
                        cnt_q   <= (cnt_q == 8'(ADDR_BYTES - 1)) ? 8'd0 : cnt_q + 8'd1;
                    end
                    S_RW: begin
                        rw_q    <= rx_byte;
                        chk_acc <= chk_acc + rx_byte;
                        cnt_q   <= '0;
                    end
                    S_DATA: begin
                        data_sh <= (data_sh << 8) | DW'(rx_byte);
                        chk_acc <= chk_acc + rx_byte;
                        cnt_q   <= (cnt_q == 8'(DATA_BYTES - 1)) ? 8'd0 : cnt_q + 8'd1;
                    end
                    S_CHK: chk_rx <= rx_byte;
                    S_TAIL: begin
                        if (rx_byte != TAIL)                     status_q <= ST_TAIL;
                        else if (chk_rx != chk_acc)              status_q <= ST_CHK;
                        else if (rw_q != RW_RD && rw_q != RW_WR) status_q <= ST_RW;
                        else                                     status_q <= ST_OK;
                        reg_addr  <= addr_sh;
                        reg_wdata <= data_sh;
                    end
                    default: ;
                endcase
            end

            err_cnt <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        end
    end

    rs232_pkt_tx #(
        .DATA_BYTES (DATA_BYTES),
        .HEAD       (HEAD),
        .TAIL       (TAIL)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .status  (status_q),
        .data    (resp_data),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .tx_ack  (tx_ack),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_rs232_pkt_engine.sv
// Bench for rs232_pkt_engine: drives command packets, acks response bytes with a
// configurable delay and checks them against a queue of expected bytes.
module tb_rs232_pkt_engine;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_ack;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        pkt_ok;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int popped = 0;
    int txreq_cycles = 0;
    int exp_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    rs232_pkt_engine #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .tx_ack    (tx_ack),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .pkt_ok    (pkt_ok),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Returns at the negedge inside T+1 (one cycle after the TAIL byte is taken).
    task automatic send_cmd(input logic [7:0] addr, input logic [7:0] rw, input logic [15:0] d,
                            input logic [7:0] chk_adj, input logic [7:0] tail);
        logic [7:0] chk;
        chk = addr + rw + d[15:8] + d[7:0] + chk_adj;
        send_byte(8'hA5);
        send_byte(addr);
        send_byte(rw);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(chk);
        send_byte(tail);
    endtask

    task automatic push_resp(input logic [7:0] st, input logic [15:0] d);
        logic [7:0] rchk;
        rchk = st + d[15:8] + d[7:0];
        sb.push_back(8'hA5);
        sb.push_back(st);
        sb.push_back(d[15:8]);
        sb.push_back(d[7:0]);
        sb.push_back(rchk);
        sb.push_back(8'h5A);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val(tag, {31'd0, busy}, 32'd0);
        check_val({tag, "_sb"}, sb.size(), 32'd0);
    endtask

    // Full-handshake check of a packet's T+1/T+2/T+3 behaviour; call right after send_cmd.
    task automatic check_exec(input string tag, input logic we, input logic re, input logic ok);
        check_val({tag, "_we"}, {31'd0, reg_we}, {31'd0, we});
        check_val({tag, "_re"}, {31'd0, reg_re}, {31'd0, re});
        @(negedge clk);
        check_val({tag, "_pkt_ok"}, {31'd0, pkt_ok}, {31'd0, ok});
        check_val({tag, "_we_off"}, {31'd0, reg_we | reg_re}, 32'd0);
        @(negedge clk);
        check_val({tag, "_tx_req"}, {31'd0, tx_req}, 32'd1);
        check_val({tag, "_tx_head"}, {24'd0, tx_data}, 32'hA5);
    endtask

    // Acker + scoreboard: holds off tx_ack ack_delay cycles, checks stability and order.
    initial begin
        logic [7:0] held;
        logic [7:0] exp;
        int hold = 0;
        tx_ack = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            tx_ack = 1'b0;
            if (rst || !tx_req) begin
                hold = 0;
            end else begin
                if (hold == 0) held = tx_data;
                else check_val("tx_stable", {24'd0, tx_data}, {24'd0, held});
                if (hold >= ack_delay) begin
                    exp = (sb.size() > 0) ? sb.pop_front() : ~tx_data;
                    check_val("tx_byte", {24'd0, tx_data}, {24'd0, exp});
                    popped++;
                    tx_ack = 1'b1;
                    hold = 0;
                end else begin
                    hold++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_req) txreq_cycles++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int snap;
        rst = 1'b1;
        rx_byte = '0;
        rx_valid = 1'b0;
        reg_rdata = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {24'd0, err_cnt}, 32'd0);
        check_val("rst_addr", {24'd0, reg_addr}, 32'd0);
        check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;

        // Write
        push_resp(8'h00, 16'h1234);
        send_cmd(8'h10, 8'h01, 16'h1234, 8'h00, 8'h5A);
        check_val("wr_addr", {24'd0, reg_addr}, 32'h10);
        check_val("wr_wdata", {16'd0, reg_wdata}, 32'h1234);
        check_exec("wr", 1'b1, 1'b0, 1'b1);
        wait_idle("wr_done");
        check_val("wr_err", {24'd0, err_cnt}, exp_err);

        // Read
        push_resp(8'h00, 16'hBEEF);
        send_cmd(8'h10, 8'h00, 16'h0000, 8'h00, 8'h5A);
        check_exec("rd", 1'b0, 1'b1, 1'b1);
        wait_idle("rd_done");

        // Checksum error
        push_resp(8'h01, 16'h0000);
        send_cmd(8'h10, 8'h01, 16'h1234, 8'h01, 8'h5A);
        check_exec("chk", 1'b0, 1'b0, 1'b0);
        exp_err++;
        wait_idle("chk_done");
        check_val("chk_err", {24'd0, err_cnt}, exp_err);

        // Bad tail takes precedence over a bad checksum
        push_resp(8'h02, 16'h0000);
        send_cmd(8'h10, 8'h01, 16'h1234, 8'h07, 8'h00);
        check_exec("tail", 1'b0, 1'b0, 1'b0);
        exp_err++;
        wait_idle("tail_done");

        // Bad RW code with a correct checksum
        push_resp(8'h03, 16'h0000);
        send_cmd(8'h22, 8'h02, 16'h1234, 8'h00, 8'h5A);
        check_exec("rw", 1'b0, 1'b0, 1'b0);
        exp_err++;
        wait_idle("rw_done");
        check_val("rw_err", {24'd0, err_cnt}, exp_err);

        // Garbage in IDLE is silently discarded
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("idle_err", {24'd0, err_cnt}, exp_err);

        // Timeout
        snap = txreq_cycles;
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO - 20) @(negedge clk);
        check_val("to_busy_mid", {31'd0, busy}, 32'd1);
        repeat (25) @(negedge clk);
        exp_err++;
        check_val("to_busy", {31'd0, busy}, 32'd0);
        check_val("to_err", {24'd0, err_cnt}, exp_err);
        check_val("to_no_tx", txreq_cycles, snap);
        push_resp(8'h00, 16'hA0B1);
        send_cmd(8'h33, 8'h01, 16'hA0B1, 8'h00, 8'h5A);
        check_exec("to_next", 1'b1, 1'b0, 1'b1);
        wait_idle("to_next_done");

        // Backpressure with a byte injected during RESP
        ack_delay = 7;
        push_resp(8'h00, 16'h5566);
        send_cmd(8'h44, 8'h01, 16'h5566, 8'h00, 8'h5A);
        repeat (6) @(negedge clk);
        send_byte(8'h33);
        exp_err++;
        wait_idle("bp_done");
        check_val("bp_err", {24'd0, err_cnt}, exp_err);

        // Reset during RESP after the second byte
        ack_delay = 3;
        popped = 0;
        push_resp(8'h00, 16'h0102);
        send_cmd(8'h55, 8'h01, 16'h0102, 8'h00, 8'h5A);
        n = 0;
        while (popped < 2 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_val("rs_popped", popped, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rs_tx_req", {31'd0, tx_req}, 32'd0);
        check_val("rs_busy", {31'd0, busy}, 32'd0);
        check_val("rs_err", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        sb.delete();
        exp_err = 0;
        ack_delay = 0;
        push_resp(8'h00, 16'hBEEF);
        send_cmd(8'h66, 8'h00, 16'h0000, 8'h00, 8'h5A);
        check_val("rs_next_addr", {24'd0, reg_addr}, 32'h66);
        check_exec("rs_next", 1'b0, 1'b1, 1'b1);
        wait_idle("rs_next_done");
        check_val("final_err", {24'd0, err_cnt}, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
